// File: rtl/fetch_sequencer_if.sv
// Instruction-memory and decode handshake bundle for the fetch sequencer.
interface fetch_sequencer_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [INST_W-1:0] imem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_out;
    logic [ADDR_W-1:0] inst_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_out, inst_pc,
        input  imem_ack, imem_rdata, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_out, inst_pc,
        output imem_ack, imem_rdata, inst_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// IF-stage fetch controller: owns the PC, reads instruction memory with wait
// states, hands one instruction at a time to decode, handles redirects and timeout.
module fetch_sequencer #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = 4,
    parameter int unsigned       MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              fetch_err,
    fetch_sequencer_if.master bus
);
    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERROR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [CNT_W-1:0]  wait_cnt, wait_nxt;
    logic [INST_W-1:0] inst_q, inst_nxt;
    logic [ADDR_W-1:0] ipc_q, ipc_nxt;
    logic              err_nxt;
    logic              req_q, valid_q;

    assign bus.imem_addr  = pc;
    assign bus.imem_req   = req_q;
    assign bus.inst_valid = valid_q;
    assign bus.inst_out   = inst_q;
    assign bus.inst_pc    = ipc_q;

    // Next-state and datapath; a redirect outranks everything except ERROR.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        wait_nxt  = wait_cnt;
        inst_nxt  = inst_q;
        ipc_nxt   = ipc_q;
        err_nxt   = fetch_err;
        if (state != ERROR && redirect) begin
            pc_nxt    = redirect_pc & ~ADDR_W'(3);
            wait_nxt  = '0;
            state_nxt = run ? FETCH : IDLE;
        end else begin
            case (state)
                IDLE: if (run) state_nxt = FETCH;
                FETCH: begin
                    if (bus.imem_ack) begin
                        inst_nxt  = bus.imem_rdata;
                        ipc_nxt   = pc;
                        pc_nxt    = pc + ADDR_W'(PC_STEP);
                        wait_nxt  = '0;
                        state_nxt = HOLD;
                    end else begin
                        wait_nxt = wait_cnt + CNT_W'(1);
                        if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                            state_nxt = ERROR;
                            err_nxt   = 1'b1;
                        end
                    end
                end
                HOLD: if (bus.inst_ready) state_nxt = run ? FETCH : IDLE;
                ERROR: state_nxt = ERROR;
            endcase
        end
    end

    // Request/valid are registered copies of the upcoming state decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            wait_cnt  <= '0;
            inst_q    <= '0;
            ipc_q     <= '0;
            fetch_err <= 1'b0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            wait_cnt  <= wait_nxt;
            inst_q    <= inst_nxt;
            ipc_q     <= ipc_nxt;
            fetch_err <= err_nxt;
            req_q     <= (state_nxt == FETCH);
            valid_q   <= (state_nxt == HOLD);
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a stimulus process models the expected
// instruction stream, a negedge monitor checks every decode handshake.
module tb_fetch_sequencer;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned INST_W   = 32;
    localparam int unsigned MAX_WAIT = 15;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_err;

    fetch_sequencer_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

    fetch_sequencer #(
        .ADDR_W(ADDR_W), .INST_W(INST_W), .RESET_PC(RESET_PC),
        .PC_STEP(4), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .redirect(redirect),
        .redirect_pc(redirect_pc), .fetch_err(fetch_err), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_hs     = 0;

    // Reference model: expected {inst, pc} pairs still owed to decode.
    logic [63:0] sb[$];
    logic [31:0] model_pc, pc_pend;
    logic        errored, err_pend;
    logic        redir_last, redir_pend;
    int          miss;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; run = 1'b0; redirect = 1'b0; redirect_pc = '0;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.inst_ready = 1'b0;
        sb.delete();
        model_pc = RESET_PC; pc_pend = RESET_PC;
        errored = 1'b0; err_pend = 1'b0;
        redir_last = 1'b0; redir_pend = 1'b0; miss = 0;
        @(posedge clk); #1;
        chk("rst_req", 64'(bus.imem_req), 64'd0);
        chk("rst_valid", 64'(bus.inst_valid), 64'd0);
        chk("rst_inst", 64'(bus.inst_out), 64'd0);
        chk("rst_ipc", 64'(bus.inst_pc), 64'd0);
        chk("rst_err", 64'(fetch_err), 64'd0);
        chk("rst_addr", 64'(bus.imem_addr), 64'(RESET_PC));
        reset = 1'b1;
    endtask

    // One cycle of stimulus, issued just after a rising edge.
    task automatic step(input logic r, input logic rd, input logic [31:0] rpc,
                        input logic ak, input logic rdy, input logic [31:0] data);
        logic fetching;
        fetching     = bus.imem_req;
        run          = r;
        redirect     = rd;
        redirect_pc  = rpc;
        bus.imem_ack = ak & fetching;
        bus.imem_rdata = data;
        bus.inst_ready = rdy;
        redir_pend   = 1'b0;
        if (rd && !errored) begin
            sb.delete();
            pc_pend    = {rpc[31:2], 2'b00};
            miss       = 0;
            redir_pend = 1'b1;
        end else if (!errored && fetching) begin
            if (ak) begin
                sb.push_back({data, model_pc});
                pc_pend = model_pc + 32'd4;
                miss    = 0;
            end else begin
                miss++;
                if (miss == int'(MAX_WAIT)) err_pend = 1'b1;
            end
        end
        @(posedge clk); #1;
        model_pc   = pc_pend;
        errored    = err_pend;
        redir_last = redir_pend;
    endtask

    // Monitor: protocol invariants plus scoreboard pop on every accepted instruction.
    always @(negedge clk) begin
        logic [63:0] exp;
        if (bus.imem_req) chk("imem_addr", 64'(bus.imem_addr), 64'(model_pc));
        chk("fetch_err", 64'(fetch_err), 64'(errored));
        if (errored) chk("err_quiet", 64'({bus.imem_req, bus.inst_valid}), 64'd0);
        if (redir_last) chk("valid_after_redirect", 64'(bus.inst_valid), 64'd0);
        if (bus.inst_valid && bus.inst_ready && !redirect) begin
            n_hs++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_inst: got pc %h, expected none", bus.inst_pc);
            end else begin
                exp = sb.pop_front();
                chk("inst_out", 64'(bus.inst_out), 64'(exp[63:32]));
                chk("inst_pc", 64'(bus.inst_pc), 64'(exp[31:0]));
            end
        end
    end

    initial begin
        int hs0;
        do_reset();

        // Back-to-back same-cycle acks: one instruction every two cycles.
        hs0 = n_hs;
        repeat (9) step(1, 0, 0, 1, 1, $urandom);
        chk("throughput", 64'(n_hs - hs0), 64'd4);

        // Three wait states before the ack.
        do_reset();
        step(1, 0, 0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 32'hDEADBEEF);
        chk("wait_inst", 64'(bus.inst_out), 64'h0000_0000_DEADBEEF);
        chk("wait_ipc", 64'(bus.inst_pc), 64'd0);
        chk("wait_pc", 64'(bus.imem_addr), 64'd4);

        // Decode stalls: held instruction stays put, no new request.
        repeat (5) begin
            step(1, 0, 0, 0, 0, 0);
            chk("hold_inst", 64'(bus.inst_out), 64'h0000_0000_DEADBEEF);
            chk("hold_ipc", 64'(bus.inst_pc), 64'd0);
            chk("hold_req", 64'(bus.imem_req), 64'd0);
        end
        step(1, 0, 0, 0, 1, 0);
        chk("resume_req", 64'(bus.imem_req), 64'd1);

        // Redirect coinciding with ack drops the ack data.
        step(1, 1, 32'h0000_0103, 1, 0, 32'h1111_1111);
        chk("redir_addr", 64'(bus.imem_addr), 64'h100);
        chk("redir_inst_kept", 64'(bus.inst_out), 64'h0000_0000_DEADBEEF);
        step(1, 0, 0, 1, 0, 32'h2222_2222);
        chk("redir_ipc", 64'(bus.inst_pc), 64'h100);
        step(1, 0, 0, 0, 1, 0);

        // PC wrap, then run=0 at the handshake parks the sequencer.
        step(1, 1, 32'hFFFF_FFFC, 0, 0, 0);
        step(1, 0, 0, 1, 0, 32'h3333_3333);
        chk("wrap_ipc_hi", 64'(bus.inst_pc), 64'hFFFF_FFFC);
        chk("wrap_addr", 64'(bus.imem_addr), 64'd0);
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0, 32'h4444_4444);
        chk("wrap_ipc_lo", 64'(bus.inst_pc), 64'd0);
        step(0, 0, 0, 0, 1, 0);
        repeat (3) begin
            step(0, 0, 0, 1, 0, 0);
            chk("idle_req", 64'({bus.imem_req, bus.inst_valid}), 64'd0);
        end

        // Timeout: fifteen unanswered cycles, redirect ignored, reset recovers.
        step(1, 0, 0, 0, 0, 0);
        repeat (MAX_WAIT) step(1, 0, 0, 0, 0, 0);
        chk("timeout_err", 64'(fetch_err), 64'd1);
        chk("timeout_req", 64'(bus.imem_req), 64'd0);
        step(1, 1, 32'h40, 1, 1, 0);
        chk("err_redir_addr", 64'(bus.imem_addr), 64'd4);
        chk("err_redir_err", 64'(fetch_err), 64'd1);
        do_reset();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            if ((errored && $urandom_range(0, 7) == 0) || $urandom_range(0, 499) == 0)
                do_reset();
            else
                step($urandom_range(0, 7) != 0,
                     $urandom_range(0, 19) == 0,
                     ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : 32'($urandom),
                     $urandom_range(0, 2) == 0,
                     $urandom_range(0, 1) == 1,
                     32'($urandom));
        end
        step(0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
